imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_word_packer.sv | 38 +++
 rtl/imem_loader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared loader defines: memory geometry defaults and the loader state encoding.
`timescale 1ns/1ps
package imem_loader_pkg;

    localparam int DEPTH_DEFAULT  = 64;
    localparam int ADDR_W_DEFAULT = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_e;

    // A program must hold at least one word and fit in the memory.
    function automatic logic count_ok(input logic [7:0] n, input int depth);
        return (n != 8'd0) && (int'(n) <= depth);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs four big-endian bytes into a 32-bit word; word_valid pulses the cycle after the 4th byte.
`timescale 1ns/1ps
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift;
    logic [1:0]  cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift      <= '0;
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                shift <= '0;
                cnt   <= '0;
            end else if (byte_valid) begin
                shift <= {shift[15:0], byte_data};
                cnt   <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    word       <= {shift, byte_data};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives count/payload/checksum bytes, writes instruction memory, then releases the core.
`timescale 1ns/1ps
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output loader_state_e     state
);

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // the source holds in_data stable while in_valid is high and in_ready is low.

    loader_state_e     state_d;
    logic              started;
    logic [7:0]        sum;
    logic [7:0]        total;
    logic [ADDR_W-1:0] last_addr;
    logic              accept;
    logic              load_byte;
    logic              last_write;
    logic              restart_ok;
    logic              word_valid;
    logic [31:0]       word;

    assign accept     = in_valid && in_ready;
    assign load_byte  = accept && (state == ST_LOAD);
    assign total      = sum + in_data;
    assign last_write = word_valid && (imem_addr == last_addr);
    assign restart_ok = restart && ((state == ST_RUN) || (state == ST_ERROR));

    word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart_ok),
        .byte_valid (load_byte),
        .byte_data  (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    assign imem_we    = word_valid;
    assign imem_wdata = word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_d = count_ok(in_data, DEPTH) ? ST_LOAD : ST_ERROR;
                end
            end
            ST_LOAD: begin
                if (last_write) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    state_d = (total == 8'h00) ? ST_RUN : ST_ERROR;
                end
            end
            ST_RUN, ST_ERROR: begin
                if (restart) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // started keeps in_ready low until the first edge after reset releases.
    always_comb begin
        in_ready  = started && !word_valid &&
                    ((state == ST_IDLE) || (state == ST_LOAD) || (state == ST_CHECK));
        cpu_reset = (state != ST_RUN);
        done      = (state == ST_RUN);
        error     = (state == ST_ERROR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started   <= 1'b0;
            sum       <= '0;
            imem_addr <= '0;
            last_addr <= '0;
        end else begin
            started <= 1'b1;
            if (restart_ok) begin
                sum       <= '0;
                imem_addr <= '0;
            end else begin
                if (accept) begin
                    sum <= total;
                end
                if (word_valid) begin
                    imem_addr <= imem_addr + 1'b1;
                end
                if (accept && (state == ST_IDLE)) begin
                    last_addr <= ADDR_W'(in_data - 8'd1);
                end
            end
        end
    end

endmodule
